mm2s_packet_router: RTL
=======================

# mm2s_packet_router

Receive-side counterpart of the S2MM packet filter. Accepts the single AXI Stream coming out of the MCDMA MM2S master port and demultiplexes each packet, by `tdest`, into one of `NUM_CHANNELS` per-accelerator write FIFOs. It is a two-entry skid buffer with a registered `tready`, so the FIFO-full path never reaches the DMA combinationally. Packets addressed to a nonexistent channel are discarded whole and counted.

## Interface
- `AXIS_DATA_WIDTH`, 32, stream data width
- `FIFO_DATA_WIDTH`, 32, per-channel FIFO word width
- `AXIS_KEEP_WIDTH`, AXIS_DATA_WIDTH/8, tkeep width
- `AXIS_DEST_WIDTH`, 4, tdest width
- `NUM_CHANNELS`, 2, number of downstream FIFOs (1..2^AXIS_DEST_WIDTH)
- `clk_in`  in  1  sole clock, all logic on its rising edge
- `rst_n_in`  in  1  reset, synchronous, active-low
- `SRC_AXIS_tvalid_in`  in  1  MM2S beat valid
- `SRC_AXIS_tready_out`  out  1  router ready, driven directly from a flop
- `SRC_AXIS_tdata_in`  in  AXIS_DATA_WIDTH  beat data
- `SRC_AXIS_tdest_in`  in  AXIS_DEST_WIDTH  target channel, sampled on the first beat of each packet
- `SRC_AXIS_tkeep_in`  in  AXIS_KEEP_WIDTH  ignored; only full-word beats are supported
- `SRC_AXIS_tlast_in`  in  1  end of packet
- `SRC_AXIS_tuser_in`  in  1  ignored
- `fifo_data_out`  out  FIFO_DATA_WIDTH*NUM_CHANNELS  write data; all channel slices carry the same word
- `fifo_last_out`  out  NUM_CHANNELS  tlast flag stored with the word
- `fifo_w_stb_out`  out  NUM_CHANNELS  one-hot write strobe
- `fifo_not_full_in`  in  NUM_CHANNELS  per-FIFO space available
- `drop_count_out`  out  16  dropped-packet count, saturating
- `err_dest_change_out`  out  1  sticky; set when tdest changes mid-packet

## Operation
- **Accept.** A beat is accepted when `tvalid_in && tready_out`.
- **Packet-start tracking.** The `in_pkt` flag is 0 after reset.
  - The first accepted beat with `in_pkt=0` latches `dest_q = tdest_in` and sets `in_pkt`.
  - An accepted beat with `tlast_in` clears `in_pkt`.
  - A single-beat packet is a start and an end on the same beat.
- **Destination per beat.**
  - Start beat: uses `tdest_in`.
  - Later beats: use `dest_q`.
  - If a later beat has `tdest_in != dest_q`, set `err_dest_change_out`. It clears only on reset, and the beat still routes to `dest_q`.
- **Drop decision.** `drop = (dest >= NUM_CHANNELS)`, fixed for the whole packet.
- **Stored beat.** Each entry holds `{data, last, sel, drop}`.
- **Width rule.** The FIFO word is `tdata[FIFO_DATA_WIDTH-1:0]` when FIFO_DATA_WIDTH ≤ AXIS_DATA_WIDTH; otherwise tdata is zero-extended.
- **Output register (`out_*`).**
  - `fifo_w_stb_out[i] = out_valid && !out_drop && out_sel==i && fifo_not_full_in[i]`.
  - Pop when `out_valid && (out_drop || fifo_not_full_in[out_sel])`. A dropped beat therefore pops in one cycle with no strobe.
- **Skid register.**
  - An accepted beat goes to `out_*` if `out_valid` will be 0 next cycle (empty or popping with the skid empty). Otherwise it goes to `skid_*`.
  - On pop with `skid_valid`: `out <= skid` and `skid_valid <= 0`, unless a new beat loads the skid in the same cycle.
  - Simultaneous accept and pop with the skid empty: the new beat loads `out_*` directly.
- **Ready.** `tready_out <= !skid_valid_next`.
- **Drop counter.** `drop_count_out` increments when a popped beat has `out_drop && out_last`, and saturates at 0xFFFF.
- **Blocked channel.** A full FIFO stalls every channel (strict in-order); there is no per-channel bypass.

## Timing
- **Reset values.**
  - `tready_out`, `fifo_w_stb_out`, `drop_count_out` and `err_dest_change_out` are 0.
  - `out_valid`, `skid_valid` and `in_pkt` are 0.
  - `fifo_data_out` and `fifo_last_out` are 0.
- **After reset.** `tready_out` rises the first cycle after `rst_n_in` goes high.
- **Latency.** A beat accepted at edge N drives `fifo_w_stb_out` in cycle N+1 when its FIFO is not full.
- **Throughput.** One beat per cycle sustained while the target FIFO stays not full.
- **Backpressure.**
  - After a FIFO deasserts `not_full`, at most one more beat is accepted, into the skid.
  - `tready_out` drops the cycle after the skid fills.
- **Reset mid-packet.** All state is cleared and a partial packet is lost. The next accepted beat is a packet start.
- **Packet boundary.** A FIFO going full exactly on a tlast beat is legal: the beat waits in `out_*`, and the next packet's start beat may sit behind it in the skid.

## Structure
- **Package `haru_dma_pkg`.**
  - Typedef `route_beat_t` with fields `data`, `last`, `sel`, `drop`.
  - `DROP_CNT_WIDTH = 16`.
  - The package is shared with the S2MM side for channel/tdest constants.
- **Sub-module `axis_skid_buffer`.** Parameterised by payload width; contains the 2-entry buffer, registered ready and pop handshake. The top level owns packet tracking, routing, strobes and counters.

## Test plan
- **Reset hold.** Hold `rst_n_in=0` 3 cycles with `tvalid=1` -> `tready_out=0` and no strobes; `tready_out=1` on the first cycle after release.
- **Single packet.** 4-beat packet with `tdest=1`, data 0xA0..0xA3, all FIFOs not full -> `fifo_w_stb_out=2'b10` on 4 consecutive cycles starting 1 cycle after the first accept, with `fifo_last_out[1]` only on 0xA3.
- **Mid-packet tdest change.** `tdest` goes 0 -> 1 on beat 2 of a 3-beat packet -> all 3 beats go to channel 0 and `err_dest_change_out=1`, which stays set.
- **Invalid destination.** `tdest=5` with `NUM_CHANNELS=2`, 3 beats, then a `tdest=0` 1-beat packet -> no strobes for the first packet, `drop_count_out=1`, then one channel-0 write.
- **Backpressure.** Streaming to channel 0; drop `fifo_not_full_in[0]` for 5 cycles -> exactly one extra beat accepted, `tready_out` low until the FIFO frees, no beat lost or duplicated and order preserved.
- **Reset mid-packet.** Assert reset after beat 2 of a `tdest=1` packet, then send a `tdest=0` packet -> the new packet routes to channel 0 (its first beat is treated as a start).

Source files
------------

// File: rtl/haru_dma_pkg.sv
// Shared DMA constants and the routed-beat payload used by the MM2S router.
// The S2MM side imports the same channel/tdest constants.
package haru_dma_pkg;

  localparam int unsigned ROUTE_DATA_WIDTH = 32;
  localparam int unsigned ROUTE_SEL_WIDTH  = 4;
  localparam int unsigned DROP_CNT_WIDTH   = 16;

  // One buffered beat: FIFO word, end-of-packet, target channel, discard flag
  typedef struct packed {
    logic [ROUTE_DATA_WIDTH-1:0] data;
    logic                        last;
    logic [ROUTE_SEL_WIDTH-1:0]  sel;
    logic                        drop;
  } route_beat_t;

  // True when a tdest value names an existing downstream channel
  function automatic logic dest_is_valid(input logic [ROUTE_SEL_WIDTH-1:0] dest,
                                         input int unsigned num_ch);
    return (32'(dest) < num_ch);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with a flop-driven ready.
// Ports:
//   clk_in, rst_n_in   clock and synchronous active-low reset
//   in_valid/in_ready  upstream handshake; in_ready comes straight from a flop
//   in_data            upstream payload
//   out_valid/out_data head entry presented downstream
//   out_pop            downstream consumes the head entry this cycle (qualified by out_valid)
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_pop
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  logic             accept_c;
  logic             pop_c;
  logic             out_valid_n;
  logic [WIDTH-1:0] out_data_n;
  logic             skid_valid_n;
  logic [WIDTH-1:0] skid_data_n;

  assign accept_c = in_valid && in_ready;
  assign pop_c    = out_valid && out_pop;

  // Next-state: drain head, promote skid, then place the accepted beat
  always_comb begin
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (pop_c) begin
      if (skid_valid) begin
        out_valid_n  = 1'b1;
        out_data_n   = skid_data;
        skid_valid_n = 1'b0;
      end else begin
        out_valid_n = 1'b0;
      end
    end
    // A new beat takes the head slot only if it would otherwise be empty
    if (accept_c) begin
      if (!out_valid_n) begin
        out_valid_n = 1'b1;
        out_data_n  = in_data;
      end else begin
        skid_valid_n = 1'b1;
        skid_data_n  = in_data;
      end
    end
  end

  // State registers; ready looks one cycle ahead at skid occupancy
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      in_ready   <= !skid_valid_n;
    end
  end

endmodule

// File: rtl/mm2s_packet_router.sv
// Demultiplexes the MCDMA MM2S stream into per-accelerator write FIFOs by tdest.
// Packets to a nonexistent channel are discarded whole and counted.
// Ports:
//   clk_in, rst_n_in             clock and synchronous active-low reset
//   SRC_AXIS_*                   MM2S AXI Stream slave (tkeep, tuser ignored)
//   fifo_data_out/fifo_last_out  write word and last flag, same on every channel slice
//   fifo_w_stb_out               one-hot write strobe
//   fifo_not_full_in             per-FIFO space available
//   drop_count_out               saturating dropped-packet count
//   err_dest_change_out          sticky flag: tdest changed inside a packet
// Data and tdest widths must match the package route_beat_t field widths.
module mm2s_packet_router
  import haru_dma_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DATA_WIDTH = ROUTE_DATA_WIDTH,
  parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int unsigned AXIS_DEST_WIDTH = ROUTE_SEL_WIDTH,
  parameter int unsigned NUM_CHANNELS    = 2
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic                                    SRC_AXIS_tvalid_in,
  output logic                                    SRC_AXIS_tready_out,
  input  logic [AXIS_DATA_WIDTH-1:0]              SRC_AXIS_tdata_in,
  input  logic [AXIS_DEST_WIDTH-1:0]              SRC_AXIS_tdest_in,
  input  logic [AXIS_KEEP_WIDTH-1:0]              SRC_AXIS_tkeep_in,
  input  logic                                    SRC_AXIS_tlast_in,
  input  logic                                    SRC_AXIS_tuser_in,
  output logic [FIFO_DATA_WIDTH*NUM_CHANNELS-1:0] fifo_data_out,
  output logic [NUM_CHANNELS-1:0]                 fifo_last_out,
  output logic [NUM_CHANNELS-1:0]                 fifo_w_stb_out,
  input  logic [NUM_CHANNELS-1:0]                 fifo_not_full_in,
  output logic [DROP_CNT_WIDTH-1:0]               drop_count_out,
  output logic                                    err_dest_change_out
);

  localparam int unsigned BEAT_WIDTH = $bits(route_beat_t);

  logic                       tready;
  logic                       accept_c;
  logic                       in_pkt;
  logic [AXIS_DEST_WIDTH-1:0] dest_q;
  logic [AXIS_DEST_WIDTH-1:0] dest_c;
  logic [FIFO_DATA_WIDTH-1:0] fifo_word_c;
  route_beat_t                in_beat_c;
  route_beat_t                out_beat;
  logic                       out_valid;
  logic                       pop_en_c;
  logic                       pop_c;
  logic                       unused_c;

  assign SRC_AXIS_tready_out = tready;
  assign accept_c            = SRC_AXIS_tvalid_in && tready;

  // Only full-word beats exist, so keep/user carry no information
  assign unused_c = ^{SRC_AXIS_tkeep_in, SRC_AXIS_tuser_in, SRC_AXIS_tdata_in};

  // Start beat routes on live tdest, the rest of the packet on the latched one
  assign dest_c = in_pkt ? dest_q : SRC_AXIS_tdest_in;

  generate
    if (FIFO_DATA_WIDTH <= AXIS_DATA_WIDTH) begin : g_word_trunc
      assign fifo_word_c = SRC_AXIS_tdata_in[FIFO_DATA_WIDTH-1:0];
    end else begin : g_word_zext
      assign fifo_word_c = FIFO_DATA_WIDTH'(SRC_AXIS_tdata_in);
    end
  endgenerate

  // Build the payload stored in the skid buffer
  always_comb begin
    in_beat_c      = '0;
    in_beat_c.data = ROUTE_DATA_WIDTH'(fifo_word_c);
    in_beat_c.last = SRC_AXIS_tlast_in;
    in_beat_c.sel  = ROUTE_SEL_WIDTH'(dest_c);
    in_beat_c.drop = !dest_is_valid(ROUTE_SEL_WIDTH'(dest_c), NUM_CHANNELS);
  end

  axis_skid_buffer #(
    .WIDTH (BEAT_WIDTH)
  ) u_skid (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .in_valid  (SRC_AXIS_tvalid_in),
    .in_ready  (tready),
    .in_data   (in_beat_c),
    .out_valid (out_valid),
    .out_data  (out_beat),
    .out_pop   (pop_en_c)
  );

  // Per-channel strobe; a full target FIFO holds the head beat (and all behind it)
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      assign fifo_w_stb_out[gi] = out_valid && !out_beat.drop &&
                                  (out_beat.sel == ROUTE_SEL_WIDTH'(gi)) &&
                                  fifo_not_full_in[gi];
      assign fifo_data_out[gi*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH] = FIFO_DATA_WIDTH'(out_beat.data);
      assign fifo_last_out[gi] = out_beat.last;
    end
  endgenerate

  // Dropped beats drain unconditionally; routed beats drain when their write fires
  assign pop_en_c = out_beat.drop || (|fifo_w_stb_out);
  assign pop_c    = out_valid && pop_en_c;

  // Packet tracking, sticky dest-change error and saturating drop counter
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      in_pkt              <= 1'b0;
      dest_q              <= '0;
      err_dest_change_out <= 1'b0;
      drop_count_out      <= '0;
    end else begin
      if (accept_c) begin
        if (!in_pkt) begin
          dest_q <= SRC_AXIS_tdest_in;
        end else if (SRC_AXIS_tdest_in != dest_q) begin
          err_dest_change_out <= 1'b1;
        end
        in_pkt <= !SRC_AXIS_tlast_in;
      end
      if (pop_c && out_beat.drop && out_beat.last && (drop_count_out != '1)) begin
        drop_count_out <= drop_count_out + DROP_CNT_WIDTH'(1);
      end
    end
  end

endmodule
